inst_mem_responder: RTL

//  Instruction-memory responder on the fetch-stage address/instruction interface.
//  - Fetch drives addr and consumes inst_o.
//  - This block returns mem[addr] with 1-cycle registered latency.
//  - Also owns a byte-serial program loader: stalls fetch while a program is written, then pulses a restart redirect to address 0.

---
 rtl/inst_mem_responder.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/inst_mem_responder.sv
// Instruction-memory responder: 1-cycle registered reads for fetch plus a byte-serial program loader.
// Optional checksum of loaded words is built only when IMEM_CHECKSUM_EN is defined.
module inst_mem_responder #(
    parameter int              WORD  = 32,
    parameter int              ADDR  = 16,
    parameter int              DEPTH = 1024,
    parameter logic [WORD-1:0] NOP   = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [ADDR-1:0] addr,
    input  logic            hold_i,
    output logic [WORD-1:0] inst_o,
    input  logic            load_v_i,
    input  logic [7:0]      load_byte_i,
    input  logic            load_last_i,
    output logic            stall_o,
    output logic            restart_o,
    output logic            load_done_o,
    output logic            load_err_o,
    output logic [WORD-1:0] checksum_o
);

    localparam int BYTES = WORD / 8;
    localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW    = $clog2(DEPTH + 1);
    localparam logic [BW-1:0] BCNT_LAST = BW'(BYTES - 1);
    localparam logic [PW-1:0] WPTR_FULL = PW'(DEPTH);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LOAD    = 2'd1;
    localparam logic [1:0] S_RESTART = 2'd2;

    logic [WORD-1:0] mem_q [DEPTH];

    logic [1:0]      state_q, state_d;
    logic [WORD-1:0] inst_q, inst_d;
    logic [WORD-1:0] asm_q, asm_d;
    logic [BW-1:0]   bcnt_q, bcnt_d;
    logic [PW-1:0]   wptr_q, wptr_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic            load_entry;
    logic            byte_take;
    logic            word_due;
    logic            addr_in_range;
    logic [WORD-1:0] asm_ins;
    logic            mem_we;
    logic [AW-1:0]   wr_idx;
    logic [WORD-1:0] wr_data;

    assign load_entry    = (state_q == S_IDLE) && load_v_i;
    assign byte_take     = ((state_q == S_LOAD) || load_entry) && load_v_i;
    assign word_due      = byte_take && ((bcnt_q == BCNT_LAST) || load_last_i);
    assign addr_in_range = (32'(addr) < 32'(DEPTH));

    // NOTE: every always_comb output is given a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        inst_d  = inst_q;
        asm_d   = asm_q;
        bcnt_d  = bcnt_q;
        wptr_d  = wptr_q;
        done_d  = done_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        wr_idx  = '0;
        wr_data = '0;

        // asm_q and bcnt_q are zero outside a load, so the entry byte lands in byte 0.
        asm_ins = asm_q;
        asm_ins[8*int'(bcnt_q) +: 8] = load_byte_i;

        case (state_q)
            S_IDLE: begin
                if (load_v_i) begin
                    state_d = S_LOAD;
                    inst_d  = NOP;
                    wptr_d  = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end else if (!hold_i) begin
                    inst_d = addr_in_range ? mem_q[addr[AW-1:0]] : NOP;
                end
            end
            S_LOAD:    inst_d = NOP;
            S_RESTART: begin
                inst_d  = NOP;
                state_d = S_IDLE;
            end
            default:   state_d = S_IDLE;
        endcase

        if (byte_take) begin
            asm_d  = asm_ins;
            bcnt_d = bcnt_q + 1'b1;
            if (word_due) begin
                asm_d   = '0;
                bcnt_d  = '0;
                wr_idx  = wptr_d[AW-1:0];
                wr_data = asm_ins;
                if (wptr_d != WPTR_FULL) begin
                    mem_we = 1'b1;
                    wptr_d = wptr_d + 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            if (load_last_i) begin
                state_d = S_RESTART;
                done_d  = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            inst_q  <= NOP;
            asm_q   <= '0;
            bcnt_q  <= '0;
            wptr_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            asm_q   <= asm_d;
            bcnt_q  <= bcnt_d;
            wptr_q  <= wptr_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // NOTE: the memory array has no reset; contents survive reset and map onto plain RAM.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[wr_idx] <= wr_data;
    end

`ifdef IMEM_CHECKSUM_EN
    logic [WORD-1:0] csum_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum_q <= '0;
        end else if (load_entry) begin
            csum_q <= mem_we ? wr_data : '0;
        end else if (mem_we) begin
            csum_q <= csum_q + wr_data;
        end
    end

    assign checksum_o = csum_q;
`else
    assign checksum_o = '0;
`endif

    assign inst_o      = inst_q;
    assign stall_o     = (state_q == S_LOAD) || load_entry;
    assign restart_o   = (state_q == S_RESTART);
    assign load_done_o = done_q;
    assign load_err_o  = err_q;

endmodule
